// File: rtl/audio_i2s_pkg.sv
// audio_i2s_pkg: I2S frame geometry and the bit-slot decode shared by the serializer.
package audio_i2s_pkg;
    localparam int FRAME_BITS  = 64;
    localparam int SLOT_BITS   = 32;
    localparam int SAMPLE_BITS = 16;
    localparam int B_W         = $clog2(FRAME_BITS);

    typedef logic [B_W-1:0] bit_idx_t;
    typedef logic [$clog2(SAMPLE_BITS)-1:0] sample_idx_t;

    typedef struct packed {
        logic        valid;
        logic        right;
        sample_idx_t idx;
    } slot_bit_t;

    // One-bit I2S delay: slot positions 1..16 carry the sample MSB first, the rest are idle.
    function automatic slot_bit_t slot_bit(input bit_idx_t b);
        slot_bit_t s;
        bit_idx_t  off;
        s.right = b >= bit_idx_t'(SLOT_BITS);
        off     = s.right ? b - bit_idx_t'(SLOT_BITS) : b;
        s.valid = off != '0 && off <= bit_idx_t'(SAMPLE_BITS);
        s.idx   = sample_idx_t'(bit_idx_t'(SAMPLE_BITS) - off);
        return s;
    endfunction
endpackage

// File: rtl/audio_i2s_tx_clk_gen.sv
// i2s_clk_gen: divides clk into SCLK, marks SCLK falling edges and tracks the frame bit position.
module i2s_clk_gen
    import audio_i2s_pkg::*;
#(
    parameter int SCLK_HALF = 2
) (
    input  logic     clk,
    input  logic     reset,
    output logic     sclk,
    output logic     lrck,
    output logic     fe,
    output logic     frame_start,
    output bit_idx_t b
);
    localparam int DIV_W = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    bit_idx_t         b_next;

    assign tick        = div == DIV_W'(SCLK_HALF - 1);
    assign fe          = tick && sclk;
    assign b_next      = b + 1'b1;
    assign frame_start = fe && b == bit_idx_t'(FRAME_BITS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            sclk <= 1'b0;
            b    <= '0;
            lrck <= 1'b0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick)
                sclk <= ~sclk;
            if (fe) begin
                b    <= b_next;
                lrck <= b_next >= bit_idx_t'(SLOT_BITS);
            end
        end
    end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: captures one stereo sample per frame and serializes it as a Philips I2S stream.
module audio_i2s_tx
    import audio_i2s_pkg::*;
#(
    parameter int CLK_RATE    = 12288000,
    parameter int SAMPLE_RATE = 48000,
    parameter int SCLK_HALF   = CLK_RATE / (SAMPLE_RATE * 128)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    input  logic        mute,
    output logic        sclk,
    output logic        lrck,
    output logic        sdata,
    output logic        sample_req
);
    logic [15:0] shadow_l;
    logic [15:0] shadow_r;
    logic        fe;
    logic        frame_start;
    bit_idx_t    b;
    slot_bit_t   sb;

    always @(posedge clk)
        assert (SCLK_HALF >= 1 && CLK_RATE % (SAMPLE_RATE * 128) == 0 &&
                SCLK_HALF * SAMPLE_RATE * 128 == CLK_RATE);

    i2s_clk_gen #(.SCLK_HALF(SCLK_HALF)) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .lrck        (lrck),
        .fe          (fe),
        .frame_start (frame_start),
        .b           (b)
    );

    // sdata is registered on fe, so it must reflect the bit position being entered.
    assign sb = slot_bit(b + 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_l   <= '0;
            shadow_r   <= '0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= frame_start;
            if (frame_start) begin
                shadow_l <= mute ? '0 : audio_l;
                shadow_r <= mute ? '0 : audio_r;
            end
            if (fe)
                sdata <= sb.valid && (sb.right ? shadow_r[sb.idx] : shadow_l[sb.idx]);
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized stimulus against a time-based I2S reference model.
module tb_audio_i2s_tx;
    localparam int SH          = 2;
    localparam int FE_CLKS     = 2 * SH;
    localparam int FRAME_CLKS  = FE_CLKS * 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] audio_l = '0;
    logic [15:0] audio_r = '0;
    logic        mute = 1'b0;
    logic        sclk, lrck, sdata, sample_req;

    int checks = 0;
    int errors = 0;

    audio_i2s_tx dut (
        .clk        (clk),
        .reset      (reset),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .mute       (mute),
        .sclk       (sclk),
        .lrck       (lrck),
        .sdata      (sdata),
        .sample_req (sample_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: e = clk edges since reset release; frame f's words are the inputs seen at edge f*FRAME_CLKS.
    int          e = 0;
    logic [15:0] cap_l [64];
    logic [15:0] cap_r [64];

    always @(posedge clk or posedge reset) begin
        if (reset)
            e <= 0;
        else begin
            e <= e + 1;
            if ((e + 1) % FRAME_CLKS == 0) begin
                cap_l[((e + 1) / FRAME_CLKS) % 64] <= mute ? 16'h0 : audio_l;
                cap_r[((e + 1) / FRAME_CLKS) % 64] <= mute ? 16'h0 : audio_r;
            end
        end
    end

    function automatic logic [15:0] word_l(input int f);
        return f == 0 ? 16'h0 : cap_l[f % 64];
    endfunction

    function automatic logic [15:0] word_r(input int f);
        return f == 0 ? 16'h0 : cap_r[f % 64];
    endfunction

    int          fe_n, bb, ff, k;
    logic [15:0] wl, wr, dl, dr;
    logic        esd, sclk_q, zor;

    always @(negedge clk) begin
        fe_n = e / FE_CLKS;
        bb   = fe_n % 64;
        ff   = fe_n / 64;
        wl   = word_l(ff);
        wr   = word_r(ff);
        esd  = (bb >= 1 && bb <= 16) ? wl[16 - bb] : (bb >= 33 && bb <= 48) ? wr[48 - bb] : 1'b0;
        check("outputs {sclk,lrck,sdata,req}", {28'h0, sclk, lrck, sdata, sample_req},
              {28'h0, 1'((e / SH) % 2), 1'(bb >= 32), esd, 1'(e > 0 && e % FRAME_CLKS == 0)});
        if (reset) begin
            k = 0; dl = '0; dr = '0; zor = 1'b0; sclk_q = 1'b0;
        end else begin
            if (sclk && !sclk_q) begin
                bb = k % 64;
                if (bb >= 1 && bb <= 16) dl = {dl[14:0], sdata};
                else if (bb >= 33 && bb <= 48) dr = {dr[14:0], sdata};
                else zor = zor | sdata;
                if (bb == 63) begin
                    check("decoded left", {16'h0, dl}, {16'h0, word_l(k / 64)});
                    check("decoded right", {16'h0, dr}, {16'h0, word_r(k / 64)});
                    check("idle slots zero", {31'h0, zor}, 32'h0);
                    zor = 1'b0;
                end
                k++;
            end
            sclk_q = sclk;
        end
    end

    task automatic wait_b(input int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((e / FE_CLKS) % 64 != t && n < 2 * FRAME_CLKS);
        check("wait_b bound", {31'h0, 1'(n < 2 * FRAME_CLKS)}, 32'h1);
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME_CLKS) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset outputs", {28'h0, sclk, lrck, sdata, sample_req}, 32'h0);
        reset = 1'b0;
        audio_l = 16'hA5C3;
        audio_r = 16'h3C5A;
        run_frames(3);
        audio_l = 16'h1234;
        wait_b(63);
        wait_b(5);
        audio_l = 16'h7FFF;
        run_frames(2);
        audio_l = 16'h8000;
        audio_r = 16'h8000;
        wait_b(63);
        wait_b(10);
        mute = 1'b1;
        run_frames(3);
        mute = 1'b0;
        run_frames(2);
        repeat (12) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            audio_l = 16'($urandom);
            audio_r = 16'($urandom);
            mute = $urandom_range(0, 3) == 0;
        end
        mute = 1'b0;
        audio_l = 16'h0F0F;
        wait_b(20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset clears outputs", {28'h0, sclk, lrck, sdata, sample_req}, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        run_frames(3);
        repeat (10) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            audio_l = 16'($urandom);
            audio_r = 16'($urandom);
            mute = $urandom_range(0, 4) == 0;
        end
        run_frames(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
